// File: rtl/dds_pkg.sv
// Shared definitions for the DDS register writer: default timing parameters,
// FSM state encoding and instruction-byte layout.
package dds_pkg;

    localparam int NBYTES_MAX_DEF  = 8;
    localparam int CS_GAP_DEF      = 2;
    localparam int IOUP_CYCLES_DEF = 4;

    // Instruction byte: {rw, 2'b00, addr}
    localparam int ADDR_W         = 5;
    localparam int INSTR_RW_BIT   = 7;
    localparam int INSTR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SEND,
        WAIT,
        CS_HOLD,
        IOUP,
        ACK
    } state_e;

    function automatic logic [7:0] instr_byte(input logic rw, input logic [ADDR_W-1:0] addr);
        logic [7:0] b;
        b = '0;
        b[INSTR_RW_BIT] = rw;
        b[INSTR_ADDR_LSB +: ADDR_W] = addr;
        return b;
    endfunction

endpackage

// File: rtl/dds_reg_writer.sv
// Sequences one DDS register access over an external byte-wide SPI engine:
// chip-select framing, instruction + data bytes, optional IO_UPDATE strobe.
module dds_reg_writer
    import dds_pkg::*;
#(
    parameter int NBYTES_MAX  = NBYTES_MAX_DEF,
    parameter int CS_GAP      = CS_GAP_DEF,
    parameter int IOUP_CYCLES = IOUP_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [4:0]  addr,
    input  logic [3:0]  nbytes,
    input  logic [63:0] wdata,
    input  logic        upd,
    output logic        busy,
    output logic        ack,
    output logic [63:0] rdata,
    output logic        CS_N,
    output logic        IO_UPDATE,
    output logic [7:0]  spi_din,
    output logic        spi_start,
    input  logic        spi_done,
    input  logic [7:0]  spi_dout
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] IOUP_LAST = CNT_W'(IOUP_CYCLES - 1);

    state_e           state;
    logic             rdy;
    logic             done_q;
    logic             rw_r, upd_r;
    logic [4:0]       addr_r;
    logic [3:0]       n_r;
    logic [63:0]      wdata_r;
    logic [3:0]       idx;
    logic [CNT_W-1:0] cnt;

    logic       done_rise;
    logic [3:0] n_in;
    logic [3:0] nxt_idx;
    logic [3:0] nxt_off;
    logic [63:0] shifted;
    logic [7:0] nxt_byte;

    assign done_rise = spi_done & ~done_q;
    assign n_in      = (nbytes > 4'(NBYTES_MAX)) ? 4'(NBYTES_MAX) : nbytes;

    // Byte about to be launched: index 0 out of CS_SETUP, idx+1 out of WAIT.
    always_comb begin
        nxt_idx  = (state == WAIT) ? idx + 4'd1 : 4'd0;
        nxt_off  = n_r - nxt_idx;
        shifted  = wdata_r >> {nxt_off[2:0], 3'b000};
        nxt_byte = (nxt_idx == 4'd0) ? instr_byte(rw_r, addr_r) : shifted[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b0;
            done_q    <= 1'b0;
            rw_r      <= 1'b0;
            upd_r     <= 1'b0;
            addr_r    <= '0;
            n_r       <= '0;
            wdata_r   <= '0;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
            CS_N      <= 1'b1;
            IO_UPDATE <= 1'b0;
            spi_din   <= '0;
            spi_start <= 1'b0;
        end else begin
            // rdy keeps the first edge after reset release from accepting a req
            rdy       <= 1'b1;
            done_q    <= spi_done;
            spi_start <= 1'b0;
            ack       <= 1'b0;
            case (state)
                IDLE: if (req && rdy) begin
                    rw_r    <= rw;
                    addr_r  <= addr;
                    n_r     <= n_in;
                    wdata_r <= wdata;
                    upd_r   <= upd;
                    busy    <= 1'b1;
                    CS_N    <= 1'b0;
                    rdata   <= '0;
                    cnt     <= '0;
                    state   <= CS_SETUP;
                end
                CS_SETUP: if (cnt == GAP_LAST) begin
                    idx       <= 4'd0;
                    spi_din   <= nxt_byte;
                    spi_start <= 1'b1;
                    state     <= SEND;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                SEND: state <= WAIT;
                WAIT: if (done_rise) begin
                    if (rw_r && idx != 4'd0)
                        rdata <= {rdata[55:0], spi_dout};
                    if (idx < n_r) begin
                        idx       <= nxt_idx;
                        spi_din   <= nxt_byte;
                        spi_start <= 1'b1;
                        state     <= SEND;
                    end else begin
                        cnt   <= '0;
                        state <= CS_HOLD;
                    end
                end
                CS_HOLD: if (cnt == GAP_LAST) begin
                    CS_N <= 1'b1;
                    cnt  <= '0;
                    if (!rw_r && upd_r) begin
                        IO_UPDATE <= 1'b1;
                        state     <= IOUP;
                    end else begin
                        ack   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ACK;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                IOUP: if (cnt == IOUP_LAST) begin
                    IO_UPDATE <= 1'b0;
                    ack       <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ACK;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_reg_writer.sv
// Bench for dds_reg_writer: SPI responder, event monitor and a transaction-level
// model of the expected byte stream, read data and IO_UPDATE activity.
`timescale 1ns/1ps
module tb_dds_reg_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, rw = 1'b0, upd = 1'b0;
    logic [4:0]  addr = '0;
    logic [3:0]  nbytes = '0;
    logic [63:0] wdata = '0;
    logic        busy, ack, CS_N, IO_UPDATE, spi_start;
    logic [63:0] rdata;
    logic [7:0]  spi_din;
    logic        spi_done = 1'b1;
    logic [7:0]  spi_dout = '0;

    dds_reg_writer dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .nbytes(nbytes),
        .wdata(wdata), .upd(upd), .busy(busy), .ack(ack), .rdata(rdata), .CS_N(CS_N),
        .IO_UPDATE(IO_UPDATE), .spi_din(spi_din), .spi_start(spi_start),
        .spi_done(spi_done), .spi_dout(spi_dout)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [7:0]  cap_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  rd_src[$];
    logic [7:0]  exp_q[$];
    logic [63:0] exp_rdata;
    logic [63:0] rdata_ack;
    int          iou_cycles, iou_pulses, ack_cnt;
    logic        iou_prev = 1'b0;
    logic [7:0]  rec_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI engine stand-in: takes a byte on spi_start, drops done, raises it 3 cycles later.
    initial forever begin
        @(posedge clk);
        if (spi_start && rst_n) begin
            rec_b = spi_din;
            #1 spi_done = 1'b0;
            repeat (3) @(posedge clk);
            #1 spi_dout = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
            spi_done = 1'b1;
            if (rst_n && busy) chk("din_stable", spi_din, rec_b);
        end
    end

    // Per-cycle observation of the DUT outputs.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (spi_start) begin
                chk("start_done_high", spi_done, 1'b1);
                chk("cs_low_at_start", CS_N, 1'b0);
                cap_q.push_back(spi_din);
            end
            if (IO_UPDATE) begin
                iou_cycles++;
                if (!iou_prev) iou_pulses++;
                chk("iou_cs_high", CS_N, 1'b1);
            end
            if (ack) begin
                ack_cnt++;
                rdata_ack = rdata;
                chk("busy_low_at_ack", busy, 1'b0);
            end
        end
        iou_prev = IO_UPDATE;
    end

    // Transaction model: what the wire must carry, derived from the access itself.
    task automatic build_model(input logic rwi, input logic [4:0] a, input logic [3:0] nb,
                               input logic [63:0] wd);
        int n;
        n = (nb > 4'd8) ? 8 : int'(nb);
        exp_q = {};
        exp_q.push_back({rwi, 2'b00, a});
        for (int k = 1; k <= n; k++) exp_q.push_back(8'(wd >> (8 * (n - k))));
        exp_rdata = '0;
        if (rwi)
            for (int k = 1; k <= n; k++)
                exp_rdata = (exp_rdata << 8) | 64'(rd_src[k]);
    endtask

    task automatic run_txn(input logic rwi, input logic [4:0] a, input logic [3:0] nb,
                           input logic [63:0] wd, input logic updi, input logic dup);
        int t;
        int m;
        build_model(rwi, a, nb, wd);
        rd_q = rd_src;
        cap_q = {};
        iou_cycles = 0; iou_pulses = 0; ack_cnt = 0;
        @(negedge clk);
        rw = rwi; addr = a; nbytes = nb; wdata = wd; upd = updi; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        #1 chk("accepted", busy, 1'b1);
        if (dup) begin
            repeat (3) @(negedge clk);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
        end
        t = 0;
        while (ack_cnt == 0 && t < 3000) begin
            @(negedge clk);
            #1 t++;
        end
        if (ack_cnt == 0) chk("ack_timeout", 1'b0, 1'b1);
        chk("byte_count", 64'(cap_q.size()), 64'(exp_q.size()));
        m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("byte%0d", i), cap_q[i], exp_q[i]);
        chk("rdata_at_ack", rdata_ack, exp_rdata);
        chk("iou_cycles", 64'(iou_cycles), (!rwi && updi) ? 64'd4 : 64'd0);
        chk("iou_pulses", 64'(iou_pulses), (!rwi && updi) ? 64'd1 : 64'd0);
        chk("ack_count", 64'(ack_cnt), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset values
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cs_n", CS_N, 1'b1);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_iou", IO_UPDATE, 1'b0);
        chk("rst_rdata", rdata, 64'd0);
        // A req seen on the first edge after release must be ignored
        rst_n = 1'b1; req = 1'b1; nbytes = 4'd1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("no_accept_first_edge", busy, 1'b0);
        repeat (3) @(negedge clk);

        // Write with IO_UPDATE
        rd_src = {};
        run_txn(1'b0, 5'h07, 4'd4, 64'h1234_5678, 1'b1, 1'b0);
        chk("lit_w_b0", cap_q[0], 8'h07);
        chk("lit_w_b1", cap_q[1], 8'h12);
        chk("lit_w_b4", cap_q[4], 8'h78);
        chk("lit_w_iou", 64'(iou_cycles), 64'd4);

        // Read back-to-back with the previous ack; first dout byte is a dummy
        rd_src = {8'hEE, 8'hA5, 8'h3C};
        run_txn(1'b1, 5'h01, 4'd2, 64'h0, 1'b1, 1'b0);
        chk("lit_r_instr", cap_q[0], 8'h81);
        chk("lit_r_rdata", rdata_ack, 64'h0000_0000_0000_A53C);

        // Instruction only
        rd_src = {};
        run_txn(1'b0, 5'h1F, 4'd0, 64'hFFFF, 1'b0, 1'b0);
        chk("lit_n0_count", 64'(cap_q.size()), 64'd1);
        chk("lit_n0_b0", cap_q[0], 8'h1F);

        // Oversized count clamps to 8 data bytes
        run_txn(1'b0, 5'h0A, 4'd15, 64'h0102_0304_0506_0708, 1'b0, 1'b0);
        chk("lit_clamp_count", 64'(cap_q.size()), 64'd9);
        chk("lit_clamp_b1", cap_q[1], 8'h01);
        chk("lit_clamp_b8", cap_q[8], 8'h08);

        // Read of 8 bytes
        rd_src = {8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_txn(1'b1, 5'h0C, 4'd8, 64'h0, 1'b0, 1'b0);

        // Second req while busy is dropped
        rd_src = {};
        run_txn(1'b0, 5'h03, 4'd2, 64'hBEEF, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        chk("dup_single_ack", 64'(ack_cnt), 64'd1);
        chk("dup_idle", busy, 1'b0);

        // Reset during the third byte of a 4-byte write
        cap_q = {};
        @(negedge clk);
        rw = 1'b0; addr = 5'h05; nbytes = 4'd4; wdata = 64'hAABB_CCDD; upd = 1'b1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        t = 0;
        while (cap_q.size() < 3 && t < 500) begin
            @(negedge clk);
            #1 t++;
        end
        chk("mid_reached_byte3", 64'(cap_q.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", CS_N, 1'b1);
        chk("mid_rst_start", spi_start, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_iou", IO_UPDATE, 1'b0);
        chk("mid_rst_din", spi_din, 8'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_txn(1'b0, 5'h09, 4'd3, 64'h00C0_FFEE, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_reg_writer.md
DDS_REG_WRITER -- requirements
Module: dds_reg_writer

Interface
REQ-001 Parameter: NBYTES_MAX, 8, maximum data bytes per transaction.
REQ-002 Parameter: CS_GAP, 2, clk cycles between CS_N change and the first or after the last SPI byte.
REQ-003 Parameter: IOUP_CYCLES, 4, IO_UPDATE pulse width in clk cycles.
REQ-004 clk  input  1  sole clock; all logic SHALL be clocked on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  one-cycle transaction request, sampled only in IDLE.
REQ-007 rw  input  1  1 = register read, 0 = register write.
REQ-008 addr  input  5  DDS register address.
REQ-009 nbytes  input  4  data byte count, 0..NBYTES_MAX.
REQ-010 wdata  input  64  write data, right-justified; low nbytes bytes are sent.
REQ-011 upd  input  1  request IO_UPDATE pulse after a write.
REQ-012 busy  output  1  high from accepted req until ack.
REQ-013 ack  output  1  one-cycle completion pulse.
REQ-014 rdata  output  64  read data, right-justified, valid from ack until next accepted req.
REQ-015 CS_N  output  1  DDS chip select, active low.
REQ-016 IO_UPDATE  output  1  DDS register-transfer strobe.
REQ-017 spi_din  output  8  byte to spi_interface din.
REQ-018 spi_start  output  1  one-cycle start to spi_interface.
REQ-019 spi_done  input  1  spi_interface done level; a byte is complete on its registered 0->1 transition.
REQ-020 spi_dout  input  8  byte received by spi_interface, valid when spi_done rises.

Function
REQ-021 States SHALL be IDLE, CS_SETUP, SEND, WAIT, CS_HOLD, IOUP, ACK.
REQ-022 IDLE: req=1 SHALL latch rw, addr, nbytes (clamped to NBYTES_MAX if larger), wdata and upd; assert busy, drive CS_N low, enter CS_SETUP; clear rdata to 0.
REQ-023 req while busy=1 SHALL be ignored and not queued.
REQ-024 CS_SETUP SHALL last CS_GAP cycles, then enter SEND with byte index 0.
REQ-025 Byte 0 SHALL be the instruction {rw, 2'b00, addr}; byte k (1..n) SHALL be wdata[8*(n-k)+:8], MSB byte first.
REQ-026 SEND SHALL drive spi_din and pulse spi_start for exactly one cycle, then enter WAIT; spi_din SHALL hold stable through WAIT.
REQ-027 WAIT SHALL exit on spi_done rising edge; if rw=1 and index>=1, rdata SHALL become {rdata[55:0], spi_dout} on that edge.
REQ-028 After WAIT, if index<n, increment index and return to SEND; otherwise enter CS_HOLD.
REQ-029 nbytes=0 SHALL perform instruction byte only.
REQ-030 CS_HOLD SHALL last CS_GAP cycles with CS_N low, then drive CS_N high.
REQ-031 After CS_HOLD: if rw=0 and upd=1 enter IOUP, else ACK.
REQ-032 IOUP SHALL hold IO_UPDATE high for IOUP_CYCLES cycles, then enter ACK.
REQ-033 ACK SHALL pulse ack one cycle, deassert busy in the same cycle, return to IDLE.
REQ-034 Minimum request-to-request spacing: a req in the cycle after ack SHALL be accepted.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, CS_N=1, IO_UPDATE=0, spi_start=0, busy=0, ack=0, spi_din=0, rdata=0, counters 0, even mid-transaction.
REQ-036 First req SHALL be accepted no earlier than the second rising clk after rst_n deasserts.

Structure
REQ-037 State encodings, instruction-byte field positions and the default parameters SHALL live in a shared package dds_pkg.
REQ-038 No sub-module; a single FSM with byte-index and delay counters; spi_interface instantiated by the parent.

Verification
REQ-039 Write addr=5'h07, nbytes=4, wdata=32'h1234_5678, upd=1 -> bytes 07,12,34,56,78; CS_N low across all; one IO_UPDATE pulse of 4 cycles after CS_N high; one ack.
REQ-040 Read addr=5'h01, nbytes=2, model returns A5,3C -> instruction 81; rdata=64'h0000_0000_0000_A53C at ack; IO_UPDATE stays 0.
REQ-041 nbytes=0 write addr=5'h1F -> single byte 1F, ack, no data bytes; nbytes=15 -> exactly 8 data bytes sent.
REQ-042 Second req asserted while busy -> ignored; exactly one transaction and one ack.
REQ-043 rst_n low during third byte of a 4-byte write -> CS_N=1, spi_start=0, busy=0 immediately; next req completes normally.
REQ-044 Back-to-back: req in cycle after ack -> accepted; spi_start never asserted while spi_done low.
